pixel_burst_ctrl: RTL and testbench
===================================

# pixel_burst_ctrl

Parametrised SRAM pixel burst controller: on `start`, reads up to BURST_MAX RGB pixels from a base address and converts them to greyscale, then writes up to BURST_MAX greyscale pixels back as replicated RGB words. It sits between the edge-detection datapath and the SRAM model. Relative to the previous fixed 20-pixel controller it adds:
- parametrised burst depth, pixel width and SRAM access time;
- read-only, write-only and read-then-write modes;
- a start/busy/done handshake and range checking.

## Interface
- ADDR_BITS, 16, SRAM address width
- PIX_BITS, 8, greyscale pixel width; one colour channel is also PIX_BITS
- BURST_MAX, 20, maximum pixels per phase; depth of both pixel arrays
- ACCESS_CYCLES, 10, cycles each SRAM access holds address/enable (≥1)
- CNT_BITS, $clog2(BURST_MAX+1), width of count ports
- clk  in  1  system clock
- rst  in  1  **one clock; reset is asynchronous and active-high**
- start  in  1  request; sampled only in IDLE
- mode  in  2  0=read-only, 1=write-only, 2=read-then-write, 3=reserved (treated as 2)
- rd_base, wr_base  in  ADDR_BITS  first read/write address; sampled at start
- rd_count, wr_count  in  CNT_BITS  pixels per phase; sampled at start
- wr_pix  in  BURST_MAX×PIX_BITS  pixels to write; must be stable while busy
- rd_pix  out  BURST_MAX×PIX_BITS  captured greyscale pixels
- busy  out  1  high from the cycle after start acceptance through DONE
- done  out  1  one-cycle pulse at end of operation
- err  out  1  set with done if a sampled count exceeds BURST_MAX; cleared at next accepted start
- address  out  ADDR_BITS  SRAM address
- w_data  out  3·PIX_BITS  SRAM write data {p,p,p}
- r_data  in  3·PIX_BITS  SRAM read data {R,G,B}
- read_enable, write_enable  out  1  SRAM strobes; never both high

## Operation
- States: IDLE, READ, WRITE, DONE.
- IDLE + start:
  - latch bases, counts and mode;
  - if either count > BURST_MAX → DONE with err=1 and no SRAM access;
  - else if the mode includes read and rd_count>0 → READ;
  - else if the mode includes write and wr_count>0 → WRITE;
  - else → DONE.
- READ, pixel i:
  - address=rd_base+i and read_enable=1 for ACCESS_CYCLES cycles;
  - on the last of those cycles, rd_pix[i] ← gray(r_data).
  - After pixel rd_count−1: → WRITE if the mode writes and wr_count>0, else → DONE.
- WRITE, pixel j:
  - address=wr_base+j, w_data={wr_pix[j],wr_pix[j],wr_pix[j]}, write_enable=1 for ACCESS_CYCLES cycles.
  - After pixel wr_count−1 → DONE.
- DONE: done=1 for one cycle → IDLE.
- gray(x):
  - s = R+G+B, computed at PIX_BITS+2 bits, no overflow;
  - gray = (s>>2)+(s>>4)+(s>>6)+(s>>8), truncated to PIX_BITS;
  - 765 → 251.
- Address arithmetic is modulo 2^ADDR_BITS; base+i wraps past all-ones to 0.
- rd_pix entries not read in the current burst keep their previous values.
- start while not in IDLE is ignored.

## Timing
- Reset values: state=IDLE; address, w_data, rd_pix, read_enable, write_enable, busy, done and err all 0.
- Reset mid-burst aborts immediately (asynchronous):
  - strobes drop;
  - no done pulse;
  - rd_pix cleared.
- Cycle count from start acceptance (edge k):
  - READ starts at k+1;
  - total cycles = rd_count·ACCESS_CYCLES + wr_count·ACCESS_CYCLES (executed phases only);
  - DONE is one cycle after the last access cycle;
  - done is asserted in that DONE cycle.
- No idle cycle between consecutive pixels, or between READ and WRITE.
- Address changes on the same edge that starts each access.
- All outputs are registered; no combinational path from r_data to any output.
- err-only / empty operation: done pulses at k+1.

## Structure
- Package pixel_pkg:
  - state enum pbc_state_t;
  - mode enum pbc_mode_t (MODE_RD, MODE_WR, MODE_RW);
  - function gray_of(rgb) used by this block and the testbench model.
- One sub-module, access_timer: ACCESS_CYCLES down-counter with load and a last flag. It replaces the two separate flex_counter timers.
- Pixel index counter and captured-data array stay in the top module.

## Test plan
- mode=0, rd_base=0x0100, rd_count=3, ACCESS_CYCLES=10, SRAM words FFFFFF/000000/102030:
  - rd_pix[0..2]=251/0/31;
  - done pulses exactly 31 cycles after acceptance.
- mode=2, rd_count=2, wr_count=2, wr_base=0x0200, wr_pix[0..1]=0x80/0x11:
  - SRAM 0x0200=808080, 0x0201=111111;
  - read and write strobes never overlap;
  - no gap between phases.
- mode=1, wr_base=0xFFFF, wr_count=2: writes land at 0xFFFF then 0x0000.
- rd_count=21 with BURST_MAX=20:
  - done and err at k+1;
  - no strobe asserted;
  - next valid start clears err.
- rst=1 during the 5th cycle of pixel 1 of a read burst:
  - strobes 0 asynchronously;
  - rd_pix all 0;
  - no done pulse;
  - subsequent start runs normally.
- start pulsed while busy: ignored; burst count and done timing unchanged.

Source files
------------

// File: rtl/pixel_pkg.sv
// pixel_pkg: shared state/mode types and greyscale conversion for the pixel burst controller
package pixel_pkg;
  typedef enum logic [1:0] {ST_IDLE, ST_READ, ST_WRITE, ST_DONE} pbc_state_t;
  typedef enum logic [1:0] {MODE_RD = 2'd0, MODE_WR = 2'd1, MODE_RW = 2'd2} pbc_mode_t;
  function automatic logic [31:0] gray_of(input logic [31:0] r, input logic [31:0] g, input logic [31:0] b);
    logic [31:0] s;
    s = r + g + b;
    return (s >> 2) + (s >> 4) + (s >> 6) + (s >> 8);
  endfunction
endpackage

// File: rtl/pixel_burst_ctrl_access_timer.sv
// access_timer: counts down the cycles of one SRAM access; last_o marks its final cycle
module access_timer #(
  parameter int ACCESS_CYCLES = 10
) (
  input  logic clk,
  input  logic rst,
  input  logic load_i,
  output logic last_o
);
  localparam int TW = ACCESS_CYCLES > 1 ? $clog2(ACCESS_CYCLES) : 1;
  logic [TW-1:0] cnt_q, cnt_d;
  assign last_o = cnt_q == '0;
  always_comb cnt_d = load_i ? TW'(ACCESS_CYCLES - 1) : (last_o ? cnt_q : cnt_q - 1'b1);
  always_ff @(posedge clk or posedge rst)
    if (rst) cnt_q <= '0;
    else cnt_q <= cnt_d;
endmodule

// File: rtl/pixel_burst_ctrl.sv
// pixel_burst_ctrl: SRAM burst reader (RGB to grey) and writer (grey replicated to RGB)
module pixel_burst_ctrl
  import pixel_pkg::*;
#(
  parameter int ADDR_BITS     = 16,
  parameter int PIX_BITS      = 8,
  parameter int BURST_MAX     = 20,
  parameter int ACCESS_CYCLES = 10,
  parameter int CNT_BITS      = $clog2(BURST_MAX + 1)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          start_i,
  input  logic [1:0]                    mode_i,
  input  logic [ADDR_BITS-1:0]          rd_base_i,
  input  logic [ADDR_BITS-1:0]          wr_base_i,
  input  logic [CNT_BITS-1:0]           rd_count_i,
  input  logic [CNT_BITS-1:0]           wr_count_i,
  input  logic [BURST_MAX*PIX_BITS-1:0] wr_pix_i,
  output logic [BURST_MAX*PIX_BITS-1:0] rd_pix_o,
  output logic                          busy_o,
  output logic                          done_o,
  output logic                          err_o,
  output logic [ADDR_BITS-1:0]          address_o,
  output logic [3*PIX_BITS-1:0]         w_data_o,
  input  logic [3*PIX_BITS-1:0]         r_data_i,
  output logic                          read_enable_o,
  output logic                          write_enable_o
);
  localparam logic [CNT_BITS-1:0] MAXC = CNT_BITS'(BURST_MAX);
  pbc_state_t state_q, state_d;
  pbc_mode_t mode_q, mode_d;
  logic [ADDR_BITS-1:0] wr_base_q, wr_base_d, address_d;
  logic [CNT_BITS-1:0] rd_cnt_q, rd_cnt_d, wr_cnt_q, wr_cnt_d, idx_q, idx_d, idx_n;
  logic [BURST_MAX*PIX_BITS-1:0] rd_pix_d;
  logic [3*PIX_BITS-1:0] w_data_d;
  logic [PIX_BITS-1:0] gray;
  logic re_d, we_d, busy_d, done_d, err_d, last, load, bad, rd_go, wr_go;
  access_timer #(.ACCESS_CYCLES(ACCESS_CYCLES)) u_timer (
    .clk(clk), .rst(rst), .load_i(load), .last_o(last)
  );
  always_comb begin
    state_d = state_q;
    mode_d = mode_q;
    wr_base_d = wr_base_q;
    rd_cnt_d = rd_cnt_q;
    wr_cnt_d = wr_cnt_q;
    idx_d = idx_q;
    address_d = address_o;
    err_d = err_o;
    rd_pix_d = rd_pix_o;
    idx_n = idx_q + 1'b1;
    gray = PIX_BITS'(gray_of(32'(r_data_i[3*PIX_BITS-1 -: PIX_BITS]),
                             32'(r_data_i[2*PIX_BITS-1 -: PIX_BITS]),
                             32'(r_data_i[PIX_BITS-1:0])));
    bad = rd_count_i > MAXC || wr_count_i > MAXC;
    rd_go = mode_i != 2'd1 && rd_count_i != '0;
    wr_go = mode_i != 2'd0 && wr_count_i != '0;
    case (state_q)
      ST_IDLE: if (start_i) begin
        mode_d = mode_i == 2'd0 ? MODE_RD : (mode_i == 2'd1 ? MODE_WR : MODE_RW);
        wr_base_d = wr_base_i;
        rd_cnt_d = rd_count_i;
        wr_cnt_d = wr_count_i;
        idx_d = '0;
        err_d = bad;
        address_d = rd_go ? rd_base_i : wr_base_i;
        state_d = bad ? ST_DONE : (rd_go ? ST_READ : (wr_go ? ST_WRITE : ST_DONE));
      end
      ST_READ: if (last) begin
        rd_pix_d[PIX_BITS*idx_q +: PIX_BITS] = gray;
        idx_d = idx_n != rd_cnt_q ? idx_n : '0;
        address_d = idx_n != rd_cnt_q ? address_o + 1'b1 : wr_base_q;
        state_d = idx_n != rd_cnt_q ? ST_READ : ((mode_q != MODE_RD && wr_cnt_q != '0) ? ST_WRITE : ST_DONE);
      end
      ST_WRITE: if (last) begin
        idx_d = idx_n;
        address_d = idx_n != wr_cnt_q ? address_o + 1'b1 : address_o;
        state_d = idx_n != wr_cnt_q ? ST_WRITE : ST_DONE;
      end
      default: state_d = ST_IDLE;
    endcase
    re_d = state_d == ST_READ;
    we_d = state_d == ST_WRITE;
    busy_d = state_d != ST_IDLE;
    done_d = state_d == ST_DONE;
    // each new access (first of a burst or right after a last cycle) restarts the timer
    load = (re_d || we_d) && (state_q == ST_IDLE || last);
    w_data_d = we_d ? {3{wr_pix_i[PIX_BITS*idx_d +: PIX_BITS]}} : '0;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state_q <= ST_IDLE;
      mode_q <= MODE_RD;
      wr_base_q <= '0;
      rd_cnt_q <= '0;
      wr_cnt_q <= '0;
      idx_q <= '0;
      address_o <= '0;
      w_data_o <= '0;
      rd_pix_o <= '0;
      read_enable_o <= 1'b0;
      write_enable_o <= 1'b0;
      busy_o <= 1'b0;
      done_o <= 1'b0;
      err_o <= 1'b0;
    end else begin
      state_q <= state_d;
      mode_q <= mode_d;
      wr_base_q <= wr_base_d;
      rd_cnt_q <= rd_cnt_d;
      wr_cnt_q <= wr_cnt_d;
      idx_q <= idx_d;
      address_o <= address_d;
      w_data_o <= w_data_d;
      rd_pix_o <= rd_pix_d;
      read_enable_o <= re_d;
      write_enable_o <= we_d;
      busy_o <= busy_d;
      done_o <= done_d;
      err_o <= err_d;
    end
endmodule

// File: tb/tb_pixel_burst_ctrl.sv
// tb_pixel_burst_ctrl: directed and random bursts against an SRAM model and a burst-level reference
module tb_pixel_burst_ctrl;
  localparam int AC = 10;
  localparam int BM = 20;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  logic [1:0] mode = '0;
  logic [15:0] rd_base = '0, wr_base = '0;
  logic [4:0] rd_count = '0, wr_count = '0;
  logic [159:0] wr_pix = '0;
  logic [159:0] rd_pix;
  logic busy, done, err, re, we;
  logic [15:0] address;
  logic [23:0] w_data, r_data;
  logic [23:0] mem [0:65535];
  logic [7:0] mpix [BM];
  int vectors = 0;
  int errors = 0;
  always #5 clk = ~clk;
  assign r_data = mem[address];
  pixel_burst_ctrl dut (
    .clk(clk), .rst(rst), .start_i(start), .mode_i(mode),
    .rd_base_i(rd_base), .wr_base_i(wr_base), .rd_count_i(rd_count), .wr_count_i(wr_count),
    .wr_pix_i(wr_pix), .rd_pix_o(rd_pix), .busy_o(busy), .done_o(done), .err_o(err),
    .address_o(address), .w_data_o(w_data), .r_data_i(r_data),
    .read_enable_o(re), .write_enable_o(we)
  );
  task automatic chk(input string tag, input logic [159:0] obs, input logic [159:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  function automatic logic [7:0] ref_gray(input logic [23:0] w);
    int s;
    s = int'(w[23:16]) + int'(w[15:8]) + int'(w[7:0]);
    return 8'((s >> 2) + (s >> 4) + (s >> 6) + (s >> 8));
  endfunction
  function automatic logic [159:0] model_pix();
    logic [159:0] v;
    for (int i = 0; i < BM; i++) v[i*8 +: 8] = mpix[i];
    return v;
  endfunction
  task automatic run_op(input logic [1:0] m, input logic [15:0] rb, input logic [15:0] wb,
                        input int rc, input int wc, input bit poke);
    logic [41:0] expq[$];
    logic [41:0] actq[$];
    logic [7:0] p;
    bit bad, rdx, wrx;
    int n_exp, n, overlap, nobusy, mis;
    bad = rc > BM || wc > BM;
    rdx = !bad && m != 2'd1 && rc > 0;
    wrx = !bad && m != 2'd0 && wc > 0;
    n_exp = 1 + (rdx ? rc * AC : 0) + (wrx ? wc * AC : 0);
    if (rdx)
      for (int i = 0; i < rc; i++) begin
        mpix[i] = ref_gray(mem[16'(rb + i)]);
        for (int c = 0; c < AC; c++) expq.push_back({2'b01, 16'(rb + i), 24'h0});
      end
    if (wrx)
      for (int j = 0; j < wc; j++) begin
        p = wr_pix[j*8 +: 8];
        for (int c = 0; c < AC; c++) expq.push_back({2'b10, 16'(wb + j), {p, p, p}});
      end
    @(negedge clk);
    mode = m; rd_base = rb; wr_base = wb; rd_count = 5'(rc); wr_count = 5'(wc); start = 1'b1;
    n = 0; overlap = 0; nobusy = 0;
    do begin
      @(negedge clk);
      n++;
      start = 1'b0;
      if (poke && n == 4) begin start = 1'b1; rd_count = 5'd1; end
      if (poke && n == 5) rd_count = 5'(rc);
      if (re && we) overlap++;
      if (busy !== 1'b1) nobusy++;
      if (re || we) actq.push_back({we, re, address, we ? w_data : 24'h0});
      if (we) mem[address] = w_data;
    end while (done !== 1'b1 && n < 1000);
    chk("done_cycle", n, n_exp);
    chk("err", err, bad);
    chk("overlap", overlap, 0);
    chk("busy", nobusy, 0);
    chk("trace_len", actq.size(), expq.size());
    mis = -1;
    for (int i = 0; i < actq.size() && i < expq.size(); i++)
      if (actq[i] !== expq[i] && mis < 0) mis = i;
    chk("trace_idx", mis, -1);
    chk("rd_pix", rd_pix, model_pix());
    @(negedge clk);
    chk("done_pulse", {done, busy}, 2'b00);
  endtask
  initial begin
    int nd;
    logic [15:0] rb, wb;
    for (int a = 0; a < 65536; a++) mem[a] = 24'($urandom);
    for (int i = 0; i < BM; i++) mpix[i] = '0;
    repeat (2) @(negedge clk);
    chk("rst_pix", rd_pix, '0);
    chk("rst_ctl", {address, w_data, re, we, busy, done, err}, '0);
    rst = 1'b0;
    mem[16'h0100] = 24'hFFFFFF; mem[16'h0101] = 24'h000000; mem[16'h0102] = 24'h102030;
    run_op(2'd0, 16'h0100, 16'h0000, 3, 0, 1'b0);
    chk("gray_765", rd_pix[7:0], 8'd251);
    chk("gray_0", rd_pix[15:8], 8'd0);
    chk("gray_96", rd_pix[23:16], 8'd31);
    wr_pix = {{18{8'h00}}, 8'h11, 8'h80};
    run_op(2'd2, 16'h0400, 16'h0200, 2, 2, 1'b0);
    chk("mem_200", mem[16'h0200], 24'h808080);
    chk("mem_201", mem[16'h0201], 24'h111111);
    wr_pix = {{18{8'h00}}, 8'h5A, 8'hC3};
    run_op(2'd1, 16'h0000, 16'hFFFF, 0, 2, 1'b0);
    chk("mem_ffff", mem[16'hFFFF], 24'hC3C3C3);
    chk("mem_0000", mem[16'h0000], 24'h5A5A5A);
    run_op(2'd0, 16'h0010, 16'h0000, 21, 0, 1'b0);
    run_op(2'd0, 16'h0010, 16'h0000, 1, 0, 1'b0);
    @(negedge clk);
    mode = 2'd0; rd_base = 16'h0300; rd_count = 5'd3; start = 1'b1;
    repeat (15) begin @(negedge clk); start = 1'b0; end
    chk("pre_rst", {re, busy}, 2'b11);
    #1 rst = 1'b1;
    #1;
    chk("rst_strobe", {re, we, busy, done}, 4'b0000);
    chk("rst_rdpix", rd_pix, '0);
    for (int i = 0; i < BM; i++) mpix[i] = '0;
    @(negedge clk);
    rst = 1'b0;
    nd = 0;
    repeat (40) begin @(negedge clk); if (done) nd++; end
    chk("rst_nodone", nd, 0);
    wr_pix = {5{$urandom}};
    run_op(2'd2, 16'($urandom), 16'($urandom), 4, 3, 1'b1);
    for (int t = 0; t < 30; t++) begin
      rb = ($urandom_range(0, 3) == 0) ? 16'hFFF0 + 16'($urandom_range(0, 15)) : 16'($urandom);
      wb = ($urandom_range(0, 3) == 0) ? 16'hFFF0 + 16'($urandom_range(0, 15)) : 16'($urandom);
      wr_pix = {5{$urandom}};
      run_op(2'($urandom_range(0, 3)), rb, wb,
             ($urandom_range(0, 7) == 0) ? $urandom_range(21, 22) : $urandom_range(0, 20),
             ($urandom_range(0, 7) == 0) ? $urandom_range(21, 22) : $urandom_range(0, 20),
             1'($urandom_range(0, 1)));
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
